// File: rtl/seq_digit_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide ripple-carry slice is reused
// for WIDTH/DIGIT cycles, with start/busy/done handshake, carry-out and overflow.
module seq_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             cy_q, cy_d, c_q, c_d, ovf_q, ovf_d;

    logic [31:0]      base;
    logic [DIGIT-1:0] da, db, dsum;
    logic [DIGIT:0]   chain;
    logic             last, load;

    assign base = 32'(cnt_q) * 32'(DIGIT);
    assign da   = a_q[base +: DIGIT];
    assign db   = b_q[base +: DIGIT];
    assign last = (cnt_q == CW'(N - 1));
    assign load = start && (state_q != RUN);

    // Shared ripple slice; chain[DIGIT-1] is the carry into the slice MSB,
    // which on the last digit is the carry into the operand MSB.
    assign chain[0] = cy_q;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign dsum[gi]      = da[gi] ^ db[gi] ^ chain[gi];
            assign chain[gi + 1] = (da[gi] & db[gi]) | (chain[gi] & (da[gi] ^ db[gi]));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cy_d    = cy_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        if (load) begin
            a_d     = x;
            b_d     = sub ? ~y : y;
            cy_d    = sub | z;
            s_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    s_d[base +: DIGIT] = dsum;
                    cy_d  = chain[DIGIT];
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        c_d     = chain[DIGIT];
                        ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cy_q    <= cy_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign c    = c_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_digit_adder.sv
// Directed bench for seq_digit_adder: DIGIT=8 main instance, plus DIGIT=1 and
// DIGIT=32 instances sharing the same inputs for the width-independence case.
module tb_seq_digit_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        z = 1'b0, sub = 1'b0;

    logic        busy8, done8, c8, ovf8;
    logic [31:0] s8;
    logic        busy1, done1, c1, ovf1;
    logic [31:0] s1;
    logic        busy32, done32, c32, ovf32;
    logic [31:0] s32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_digit_adder #(.WIDTH(32), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z), .sub(sub),
        .busy(busy8), .done(done8), .s(s8), .c(c8), .ovf(ovf8));
    seq_digit_adder #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z), .sub(sub),
        .busy(busy1), .done(done1), .s(s1), .c(c1), .ovf(ovf1));
    seq_digit_adder #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z), .sub(sub),
        .busy(busy32), .done(done32), .s(s32), .c(c32), .ovf(ovf32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation on the DIGIT=8 instance, from start pulse to done pulse.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic zi, input logic si,
                         input logic [31:0] es, input logic ec, input logic eo);
        int bc;
        int n;
        @(negedge clk);
        x = a; y = b; z = zi; sub = si; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        n = 0;
        while (!done8 && n < 100) begin
            if (busy8) bc++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".busy_cycles"}, 64'(bc), 64'd4);
        chk({tag, ".done"}, 64'(done8), 64'd1);
        chk({tag, ".s"}, 64'(s8), 64'(es));
        chk({tag, ".c"}, 64'(c8), 64'(ec));
        chk({tag, ".ovf"}, 64'(ovf8), 64'(eo));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done8), 64'd0);
        chk({tag, ".s_hold"}, 64'(s8), 64'(es));
        $display("op %s: x=%h y=%h z=%b sub=%b -> s=%h c=%b ovf=%b", tag, a, b, zi, si, s8, c8, ovf8);
    endtask

    logic [31:0] bx [4] = '{32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic [31:0] by [4] = '{32'h2, 32'h1, 32'h1, 32'h11111111};
    logic        bsub [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bs [4] = '{32'h3, 32'h0, 32'h7FFFFFFF, 32'h23456789};
    logic        bc_e [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        bo_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int k, cyc, n, b1, b32, dn;
        logic [31:0] r1, r32;
        logic rc1, rc32, ro1, ro32, got1, got32;

        repeat (2) @(negedge clk);
        chk("reset.busy", 64'(busy8), 64'd0);
        chk("reset.done", 64'(done8), 64'd0);
        chk("reset.s", 64'(s8), 64'd0);
        chk("reset.c", 64'(c8), 64'd0);
        chk("reset.ovf", 64'(ovf8), 64'd0);
        rst_n = 1'b1;

        do_op("zero", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_op("ff_z0", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
        do_op("ff_z1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        do_op("ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        do_op("sub5_7", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub7_5", 32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);

        // Back-to-back: start held high, garbage operands while RUN.
        @(negedge clk);
        x = bx[0]; y = by[0]; z = 1'b0; sub = bsub[0]; start = 1'b1;
        k = 0; cyc = 0; n = 0;
        while (k < 4 && n < 100) begin
            @(negedge clk);
            cyc++; n++;
            if (done8) begin
                chk($sformatf("b2b%0d.s", k), 64'(s8), 64'(bs[k]));
                chk($sformatf("b2b%0d.c", k), 64'(c8), 64'(bc_e[k]));
                chk($sformatf("b2b%0d.ovf", k), 64'(ovf8), 64'(bo_e[k]));
                chk($sformatf("b2b%0d.spacing", k), 64'(cyc), 64'd5);
                $display("op b2b%0d: s=%h c=%b ovf=%b after %0d cycles", k, s8, c8, ovf8, cyc);
                cyc = 0;
                k++;
                if (k < 4) begin
                    x = bx[k]; y = by[k]; z = 1'b0; sub = bsub[k];
                end else begin
                    start = 1'b0;
                end
            end else begin
                x = $urandom; y = $urandom; z = 1'($urandom); sub = 1'($urandom);
            end
        end
        chk("b2b.count", 64'(k), 64'd4);
        start = 1'b0; z = 1'b0; sub = 1'b0;
        repeat (40) @(negedge clk);

        // Reset asserted around E2 of an operation.
        x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy8), 64'd0);
        chk("abort.s", 64'(s8), 64'd0);
        chk("abort.c", 64'(c8), 64'd0);
        chk("abort.ovf", 64'(ovf8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("abort.no_done", 64'(dn), 64'd0);
        $display("op abort: reset mid-run, done pulses seen=%0d", dn);
        do_op("post_abort", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        repeat (40) @(negedge clk);

        // Same operation on DIGIT=1 and DIGIT=32 instances.
        x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; z = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b1 = 0; b32 = 0; got1 = 1'b0; got32 = 1'b0;
        r1 = '0; r32 = '0; rc1 = 1'b0; rc32 = 1'b0; ro1 = 1'b0; ro32 = 1'b0;
        n = 0;
        while (!(got1 && got32) && n < 60) begin
            if (busy1) b1++;
            if (busy32) b32++;
            if (done1 && !got1) begin got1 = 1'b1; r1 = s1; rc1 = c1; ro1 = ovf1; end
            if (done32 && !got32) begin got32 = 1'b1; r32 = s32; rc32 = c32; ro32 = ovf32; end
            @(negedge clk);
            n++;
        end
        chk("d1.done", 64'(got1), 64'd1);
        chk("d1.busy_cycles", 64'(b1), 64'd32);
        chk("d1.s", 64'(r1), 64'hFFFFFFFE);
        chk("d1.c", 64'(rc1), 64'd1);
        chk("d1.ovf", 64'(ro1), 64'd0);
        chk("d32.done", 64'(got32), 64'd1);
        chk("d32.busy_cycles", 64'(b32), 64'd1);
        chk("d32.s", 64'(r32), 64'hFFFFFFFE);
        chk("d32.c", 64'(rc32), 64'd1);
        chk("d32.ovf", 64'(ro32), 64'd0);
        $display("op digit_sweep: d1 s=%h c=%b ovf=%b, d32 s=%h c=%b ovf=%b", r1, rc1, ro1, r32, rc32, ro32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
